serial_mod_checker: RTL and testbench
=====================================

Name: serial_mod_checker

Overview:
- Bit-serial divisibility checker for one binary stream. It tracks the running remainder of the stream modulo a parametrised DIVISOR.
- Generalises the fixed modulo-3 MSB-first detector: any divisor, a selectable bit order, a valid qualifier, frame delimiting, a per-frame verdict and a saturating bit counter.
- Sits between a serial deserialiser front end and the status/interrupt logic.

Parameters:
- DIVISOR, 3, modulus; legal range 2..256; elaboration error outside the range.
- LSB_FIRST, 0, 0 = stream arrives MSB-first, 1 = stream arrives LSB-first.
- CNT_W, 16, width of the bit counter.
- REM_W, $clog2(DIVISOR), derived width of the remainder; not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous frame abort/restart
- bit_valid  in  1  bit_in is valid this cycle
- bit_in  in  1  serial data bit
- last  in  1  qualifies bit_valid: this bit ends the frame
- rem_out  out  REM_W  running remainder (registered)
- div_now  out  1  rem_out == 0 (registered)
- frame_done  out  1  one-cycle pulse after the accepted last bit
- frame_div  out  1  verdict of the most recent completed frame; held until the next frame_done
- frame_rem  out  REM_W  final remainder of the most recent completed frame; held
- bit_count  out  CNT_W  bits accepted in the current frame; saturates
- count_sat  out  1  bit_count reached all-ones in the current frame (sticky per frame)

Behaviour:
- Reset (asynchronous, active-high) values:
  - rem_out = 0, div_now = 1, frame_done = 0, frame_div = 0, frame_rem = 0, bit_count = 0, count_sat = 0.
  - Internal LSB weight w = 1; state = IDLE.
- MSB-first update on an accepted bit: t = 2*rem + bit_in; if t >= DIVISOR then t = t - DIVISOR.
  - t < 2*DIVISOR always holds, so a single conditional subtract is sufficient.
  - Intermediate width is REM_W+1 bits.
- LSB-first update on an accepted bit:
  - rem = (rem + (bit_in ? w : 0)), reduced with one conditional subtract.
  - w = (2*w), reduced with one conditional subtract.
  - w resets to 1 at reset, on clear and at frame end.
- Latency: rem_out and div_now reflect an accepted bit one cycle after the bit_valid cycle. With bit_valid = 0, all state holds.
- State machine:
  - IDLE: no bits accepted in the frame yet. Goes to ACTIVE on bit_valid & ~last. Goes to DONE on bit_valid & last (single-bit frame).
  - ACTIVE: accumulating. Goes to DONE on bit_valid & last.
  - DONE: one cycle, frame_done = 1. Goes to IDLE, or to ACTIVE/DONE if a bit is accepted in this cycle (back-to-back frames supported, no bubble).
- Frame end, in the cycle after the accepted last bit:
  - frame_done = 1.
  - frame_rem = final remainder; frame_div = (final remainder == 0).
  - rem_out shows the final remainder for that one cycle.
  - The internal accumulator restarts at 0 (w = 1) for the next bit.
  - bit_count and count_sat clear for the next frame.
- A bit accepted during DONE starts a new frame from remainder 0. That bit's contribution appears in rem_out on the following cycle.
- last with bit_valid = 0 is ignored.
- bit_count:
  - Increments per accepted bit and stops at 2^CNT_W-1.
  - count_sat sets when that value is reached and stays set until frame end, clear or reset.
  - Remainder tracking continues regardless of saturation.
- clear takes priority over bit_valid in the same cycle; the bit is dropped.
  - Next cycle: rem_out = 0, div_now = 1, bit_count = 0, count_sat = 0, w = 1, state = IDLE, frame_done = 0.
  - frame_div and frame_rem keep their held values.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously); the partial frame is discarded and produces no frame_done.

Test Plan:
- DIVISOR=3, MSB-first, bits 0,1,1,0,1 (last on the 5th bit) -> rem_out 0,1,0,0,1 over successive cycles; frame_done pulses once; frame_div = 0; frame_rem = 1; bit_count reaches 5.
- DIVISOR=7, MSB-first, bits 1,1,0,0,0,1 (value 49) -> rem_out 1,3,6,5,3,0; frame_div = 1; frame_rem = 0.
- DIVISOR=5, LSB_FIRST=1, bits 1,0,1 (value 5) -> rem_out 1,1,0; frame_div = 1. Then a back-to-back frame of bits 1,1 (value 3) -> rem_out 1,3; frame_div = 0; frame_rem = 3.
- DIVISOR=3, bits 1,0 then clear asserted together with bit_valid=1 -> bit dropped; next cycle rem_out = 0, bit_count = 0; no frame_done; previous frame_div unchanged.
- CNT_W=3, 10 valid bits of 1 with DIVISOR=3 -> bit_count saturates at 7 and count_sat = 1 from the 7th bit; final frame_rem = (2^10-1) mod 3 = 0, frame_div = 1.
- Reset asserted asynchronously mid-frame after 3 bits -> outputs immediately at reset values; no frame_done pulse; a subsequent frame evaluates from remainder 0.

Source files
------------

// File: rtl/serial_mod_checker_if.sv
// rtl/serial_mod_checker_if.sv - serial bit stream in, remainder and frame status out
interface serial_mod_checker_if #(
    parameter int REM_W = 2,
    parameter int CNT_W = 16
);
    logic             clear;
    logic             bit_valid;
    logic             bit_in;
    logic             last;
    logic [REM_W-1:0] rem_out;
    logic             div_now;
    logic             frame_done;
    logic             frame_div;
    logic [REM_W-1:0] frame_rem;
    logic [CNT_W-1:0] bit_count;
    logic             count_sat;

    modport master (
        output clear, bit_valid, bit_in, last,
        input  rem_out, div_now, frame_done, frame_div, frame_rem, bit_count, count_sat
    );

    modport slave (
        input  clear, bit_valid, bit_in, last,
        output rem_out, div_now, frame_done, frame_div, frame_rem, bit_count, count_sat
    );
endinterface

// File: rtl/serial_mod_checker.sv
// rtl/serial_mod_checker.sv - bit-serial running remainder modulo DIVISOR with per-frame verdict
module serial_mod_checker #(
    parameter int DIVISOR   = 3,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = 16,
    parameter int REM_W     = $clog2(DIVISOR)
) (
    input  logic                clk,
    input  logic                reset,
    serial_mod_checker_if.slave bus
);
    if (DIVISOR < 2 || DIVISOR > 256) begin : g_bad_divisor
        $error("serial_mod_checker: DIVISOR must be within 2..256");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [REM_W:0]   DIV_X   = (REM_W+1)'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_d;
    logic [REM_W-1:0] rem_q, w_q, rem_d, w_d;
    logic [REM_W-1:0] base_rem, base_w;
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
    logic             sat_q, sat_d, base_sat;
    logic             div_q, frame_div_q;
    logic [REM_W-1:0] frame_rem_q;
    logic [REM_W:0]   sum, dbl;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        accept   = bus.bit_valid && !bus.clear;
        // The cycle after a last bit shows the finished frame; the next bit builds on a fresh accumulator.
        base_rem = (state == DONE) ? '0 : rem_q;
        base_w   = (state == DONE) ? REM_W'(1) : w_q;
        base_cnt = (state == DONE) ? '0 : cnt_q;
        base_sat = (state == DONE) ? 1'b0 : sat_q;
        rem_d    = base_rem;
        w_d      = base_w;
        cnt_d    = base_cnt;
        sat_d    = base_sat;
        state_d  = state;

        if (LSB_FIRST != 0) begin
            sum = {1'b0, base_rem} + (bus.bit_in ? {1'b0, base_w} : {(REM_W+1){1'b0}});
        end else begin
            sum = {base_rem, bus.bit_in};
        end
        dbl = {base_w, 1'b0};

        if (accept) begin
            rem_d = (sum >= DIV_X) ? REM_W'(sum - DIV_X) : REM_W'(sum);
            if (LSB_FIRST != 0) w_d = (dbl >= DIV_X) ? REM_W'(dbl - DIV_X) : REM_W'(dbl);
            cnt_d = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 1'b1;
            sat_d = base_sat || (cnt_d == CNT_MAX);
        end

        case (state)
            IDLE, ACTIVE: if (accept) state_d = bus.last ? DONE : ACTIVE;
            DONE:         state_d = accept ? (bus.last ? DONE : ACTIVE) : IDLE;
            default:      state_d = IDLE;
        endcase

        if (bus.clear) begin
            rem_d   = '0;
            w_d     = REM_W'(1);
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q       <= '0;
            w_q         <= REM_W'(1);
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            div_q       <= 1'b1;
            frame_div_q <= 1'b0;
            frame_rem_q <= '0;
        end else begin
            rem_q <= rem_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            div_q <= (rem_d == '0);
            if (accept && bus.last) begin
                frame_rem_q <= rem_d;
                frame_div_q <= (rem_d == '0);
            end
        end
    end

    assign bus.rem_out    = rem_q;
    assign bus.div_now    = div_q;
    assign bus.frame_done = (state == DONE);
    assign bus.frame_div  = frame_div_q;
    assign bus.frame_rem  = frame_rem_q;
    assign bus.bit_count  = cnt_q;
    assign bus.count_sat  = sat_q;
endmodule

// File: tb/tb_serial_mod_checker.sv
// tb/tb_serial_mod_checker.sv - three checker configurations against a frame-level arithmetic model
module tb_serial_mod_checker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_mod_checker_if #(.REM_W(2), .CNT_W(3))  if0 ();
    serial_mod_checker_if #(.REM_W(3), .CNT_W(16)) if1 ();
    serial_mod_checker_if #(.REM_W(3), .CNT_W(16)) if2 ();

    serial_mod_checker #(.DIVISOR(3), .LSB_FIRST(0), .CNT_W(3))  u_d3  (.clk(clk), .reset(reset), .bus(if0));
    serial_mod_checker #(.DIVISOR(7), .LSB_FIRST(0), .CNT_W(16)) u_d7  (.clk(clk), .reset(reset), .bus(if1));
    serial_mod_checker #(.DIVISOR(5), .LSB_FIRST(1), .CNT_W(16)) u_d5l (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        logic v, b, l, c;
        int   sel;
        int   rem;
        int   done;
        int   fdiv;
        int   frem;
        int   cnt;
        int   sat;
    } vec_t;

    vec_t tbl[$];

    int div_of [3] = '{3, 7, 5};
    int lsb_of [3] = '{0, 0, 1};
    int cmax_of[3] = '{7, 65535, 65535};

    // Model keeps the raw bits of the open frame and evaluates its value mod DIVISOR directly.
    bit fb [3][4096];
    int flen  [3];
    int e_rem [3], e_done[3], e_fdiv[3], e_frem[3], e_cnt[3], e_sat[3];

    int vectors = 0;
    int miscompares = 0;

    function automatic int pow2mod(int p, int d);
        int r;
        r = 1 % d;
        for (int i = 0; i < p; i++) r = (r * 2) % d;
        return r;
    endfunction

    function automatic int frame_mod(int k);
        int r, pos;
        r = 0;
        for (int i = 0; i < flen[k]; i++) begin
            pos = (lsb_of[k] != 0) ? i : flen[k] - 1 - i;
            if (fb[k][i]) r = (r + pow2mod(pos, div_of[k])) % div_of[k];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            flen[k] = 0; e_rem[k] = 0; e_done[k] = 0; e_fdiv[k] = 0;
            e_frem[k] = 0; e_cnt[k] = 0; e_sat[k] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic b, input logic l, input logic c);
        for (int k = 0; k < 3; k++) begin
            e_done[k] = 0;
            if (c) begin
                flen[k] = 0;
            end else if (v && flen[k] < 4096) begin
                fb[k][flen[k]] = b;
                flen[k]++;
            end
            e_rem[k] = frame_mod(k);
            e_cnt[k] = (flen[k] < cmax_of[k]) ? flen[k] : cmax_of[k];
            e_sat[k] = (flen[k] >= cmax_of[k]) ? 1 : 0;
            if (!c && v && l) begin
                e_done[k] = 1;
                e_frem[k] = e_rem[k];
                e_fdiv[k] = (e_rem[k] == 0) ? 1 : 0;
                flen[k]   = 0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic l, input logic c);
        if0.bit_valid = v; if0.bit_in = b; if0.last = l; if0.clear = c;
        if1.bit_valid = v; if1.bit_in = b; if1.last = l; if1.clear = c;
        if2.bit_valid = v; if2.bit_in = b; if2.last = l; if2.clear = c;
    endtask

    task automatic get_out(input int k, output int rem, output int dn, output int done,
                           output int fdiv, output int frem, output int cnt, output int sat);
        case (k)
            0: begin
                rem = int'(if0.rem_out); dn = int'(if0.div_now); done = int'(if0.frame_done);
                fdiv = int'(if0.frame_div); frem = int'(if0.frame_rem);
                cnt = int'(if0.bit_count); sat = int'(if0.count_sat);
            end
            1: begin
                rem = int'(if1.rem_out); dn = int'(if1.div_now); done = int'(if1.frame_done);
                fdiv = int'(if1.frame_div); frem = int'(if1.frame_rem);
                cnt = int'(if1.bit_count); sat = int'(if1.count_sat);
            end
            default: begin
                rem = int'(if2.rem_out); dn = int'(if2.div_now); done = int'(if2.frame_done);
                fdiv = int'(if2.frame_div); frem = int'(if2.frame_rem);
                cnt = int'(if2.bit_count); sat = int'(if2.count_sat);
            end
        endcase
    endtask

    task automatic chk(input string name, input int k, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d", name, k, act, exp);
        end
    endtask

    task automatic compare_model();
        int rem, dn, done, fdiv, frem, cnt, sat;
        for (int k = 0; k < 3; k++) begin
            get_out(k, rem, dn, done, fdiv, frem, cnt, sat);
            chk("rem_out",    k, rem,  e_rem[k]);
            chk("div_now",    k, dn,   (e_rem[k] == 0) ? 1 : 0);
            chk("frame_done", k, done, e_done[k]);
            chk("frame_div",  k, fdiv, e_fdiv[k]);
            chk("frame_rem",  k, frem, e_frem[k]);
            chk("bit_count",  k, cnt,  e_cnt[k]);
            chk("count_sat",  k, sat,  e_sat[k]);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic l, input logic c);
        drive(v, b, l, c);
        @(posedge clk);
        #1;
        model_step(v, b, l, c);
        compare_model();
    endtask

    function automatic void add(input logic v, input logic b, input logic l, input logic c, input int sel,
                                input int rem, input int done, input int fdiv, input int frem,
                                input int cnt, input int sat);
        vec_t e;
        e.v = v; e.b = b; e.l = l; e.c = c; e.sel = sel;
        e.rem = rem; e.done = done; e.fdiv = fdiv; e.frem = frem; e.cnt = cnt; e.sat = sat;
        tbl.push_back(e);
    endfunction

    task automatic check_reset_values(input string tag);
        int rem, dn, done, fdiv, frem, cnt, sat;
        for (int k = 0; k < 3; k++) begin
            get_out(k, rem, dn, done, fdiv, frem, cnt, sat);
            chk({tag, "_rem"},  k, rem,  0);
            chk({tag, "_div"},  k, dn,   1);
            chk({tag, "_done"}, k, done, 0);
            chk({tag, "_fdiv"}, k, fdiv, 0);
            chk({tag, "_frem"}, k, frem, 0);
            chk({tag, "_cnt"},  k, cnt,  0);
            chk({tag, "_sat"},  k, sat,  0);
        end
    endtask

    initial begin
        int rem, dn, done, fdiv, frem, cnt, sat;

        // DIVISOR=3 MSB-first: 0,1,1,0,1
        add(1,0,0,0, 0, 0,0,0,0, 1,0);
        add(1,1,0,0, 0, 1,0,0,0, 2,0);
        add(1,1,0,0, 0, 0,0,0,0, 3,0);
        add(1,0,0,0, 0, 0,0,0,0, 4,0);
        add(1,1,1,0, 0, 1,1,0,1, 5,0);
        add(0,0,0,0, 0, 0,0,0,1, 0,0);
        // DIVISOR=7 MSB-first: 49
        add(1,1,0,0, 1, 1,0,0,6, 1,0);
        add(1,1,0,0, 1, 3,0,0,6, 2,0);
        add(1,0,0,0, 1, 6,0,0,6, 3,0);
        add(1,0,0,0, 1, 5,0,0,6, 4,0);
        add(1,0,0,0, 1, 3,0,0,6, 5,0);
        add(1,1,1,0, 1, 0,1,1,0, 6,0);
        add(0,0,0,0, 1, 0,0,1,0, 0,0);
        // DIVISOR=5 LSB-first: 5 then back-to-back 3
        add(1,1,0,0, 2, 1,0,1,0, 1,0);
        add(1,0,0,0, 2, 1,0,1,0, 2,0);
        add(1,1,1,0, 2, 0,1,1,0, 3,0);
        add(1,1,0,0, 2, 1,0,1,0, 1,0);
        add(1,1,1,0, 2, 3,1,0,3, 2,0);
        add(0,0,0,0, 2, 0,0,0,3, 0,0);
        // clear drops a concurrent last bit
        add(1,1,0,0, 0, 1,0,1,0, 1,0);
        add(1,0,0,0, 0, 2,0,1,0, 2,0);
        add(1,1,1,1, 0, 0,0,1,0, 0,0);
        add(0,0,0,0, 0, 0,0,1,0, 0,0);
        // CNT_W=3 saturation over ten ones
        for (int k = 1; k <= 10; k++)
            add(1, 1, (k == 10), 0, 0, k % 2, (k == 10) ? 1 : 0, 1, 0,
                (k < 7) ? k : 7, (k >= 7) ? 1 : 0);
        add(0,0,0,0, 0, 0,0,1,0, 0,0);

        reset = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        #1;
        check_reset_values("init");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].c);
            get_out(tbl[i].sel, rem, dn, done, fdiv, frem, cnt, sat);
            chk($sformatf("tbl%0d_rem", i),  tbl[i].sel, rem,  tbl[i].rem);
            chk($sformatf("tbl%0d_done", i), tbl[i].sel, done, tbl[i].done);
            chk($sformatf("tbl%0d_fdiv", i), tbl[i].sel, fdiv, tbl[i].fdiv);
            chk($sformatf("tbl%0d_frem", i), tbl[i].sel, frem, tbl[i].frem);
            chk($sformatf("tbl%0d_cnt", i),  tbl[i].sel, cnt,  tbl[i].cnt);
            chk($sformatf("tbl%0d_sat", i),  tbl[i].sel, sat,  tbl[i].sat);
        end

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, $urandom % 2, ($urandom % 6) == 0, ($urandom % 40) == 0);
        end

        // asynchronous reset three bits into a frame
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        #1;
        reset = 1'b0;
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        get_out(0, rem, dn, done, fdiv, frem, cnt, sat);
        chk("post_rst_rem",  0, rem,  0);
        chk("post_rst_done", 0, done, 1);
        chk("post_rst_fdiv", 0, fdiv, 1);
        chk("post_rst_cnt",  0, cnt,  2);
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
